// File: rtl/ram1_bus_arbiter_pkg.sv
// Shared constants, state encoding and address decode for the RAM1/COM1 bus arbiter.
package ram1_bus_arbiter_pkg;

  localparam logic [15:0] RAM1_UPPER = 16'h8000;
  localparam logic [15:0] COM1_DATA  = 16'hBF00;
  localparam logic [15:0] COM1_CMD   = 16'hBF01;
  localparam logic [15:0] NOP_INSTR  = 16'h0800;

  // state        | meaning
  // ST_IDLE      | bus released, arbitrating (MEM before IF)
  // ST_IF_SETUP  | fetch address on bus, RAM1 output enabled
  // ST_IF_LATCH  | fetched word captured, if_valid pulse
  // ST_MEM_SETUP | data access strobes asserted
  // ST_MEM_LATCH | strobes released, mem_done pulse
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_IF_SETUP  = 3'd1,
    ST_IF_LATCH  = 3'd2,
    ST_MEM_SETUP = 3'd3,
    ST_MEM_LATCH = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    TGT_RAM1      = 2'd0,
    TGT_UART_DATA = 2'd1,
    TGT_UART_CMD  = 2'd2,
    TGT_NONE      = 2'd3
  } target_t;

  function automatic target_t decode_addr(input logic [15:0] addr);
    target_t tgt;
    if (addr < RAM1_UPPER)      tgt = TGT_RAM1;
    else if (addr == COM1_DATA) tgt = TGT_UART_DATA;
    else if (addr == COM1_CMD)  tgt = TGT_UART_CMD;
    else                        tgt = TGT_NONE;
    return tgt;
  endfunction

endpackage

// File: rtl/ram1_bus_arbiter.sv
// Arbitrates RAM1 and COM1 UART pins between IF fetch and MEM access; MEM has priority.
// Define UART_STATUS_EN to make COM1_CMD reads return {data_ready, tbre&tsre}.
module ram1_bus_arbiter
  import ram1_bus_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_pc,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic        if_stall,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_done,
  inout  wire  [15:0] ram1_data,
  output logic [17:0] ram1_addr,
  output logic        ram1_oe,
  output logic        ram1_we,
  output logic        ram1_en,
  output logic        rdn,
  output logic        wrn,
  input  logic        tbre,
  input  logic        tsre,
  input  logic        data_ready
);

  state_t      state_q, state_d;
  target_t     tgt_q, tgt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [15:0] if_instr_q, if_instr_d;
  logic [15:0] mem_rdata_q, mem_rdata_d;
  logic        bus_drive;
  logic [15:0] bus_out;
  logic [15:0] status_word;
  target_t     mem_tgt;
  logic        mem_hit;

  assign mem_tgt = decode_addr(mem_addr);
  assign mem_hit = mem_req & (mem_tgt != TGT_NONE);

`ifdef UART_STATUS_EN
  assign status_word = {14'b0, data_ready, tbre & tsre};
`else
  logic unused_status;
  assign unused_status = tbre ^ tsre ^ data_ready;
  assign status_word   = 16'h0000;
`endif

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tgt_q       <= TGT_NONE;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      we_q        <= 1'b0;
      if_instr_q  <= NOP_INSTR;
      mem_rdata_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      if_instr_q  <= if_instr_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Read data is captured on the edge leaving SETUP, while the source still drives the bus.
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    if_instr_d  = if_instr_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_hit) begin
          state_d = ST_MEM_SETUP;
          tgt_d   = mem_tgt;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          we_d    = mem_we;
        end else if (if_req) begin
          state_d = ST_IF_SETUP;
          tgt_d   = TGT_RAM1;
          addr_d  = if_pc;
          we_d    = 1'b0;
        end
      end
      ST_IF_SETUP: begin
        if_instr_d = ram1_data;
        state_d    = ST_IF_LATCH;
      end
      ST_IF_LATCH: state_d = ST_IDLE;
      ST_MEM_SETUP: begin
        if (!we_q) begin
          case (tgt_q)
            TGT_RAM1:      mem_rdata_d = ram1_data;
            TGT_UART_DATA: mem_rdata_d = {8'b0, ram1_data[7:0]};
            TGT_UART_CMD:  mem_rdata_d = status_word;
            default:       mem_rdata_d = mem_rdata_q;
          endcase
        end
        state_d = ST_MEM_LATCH;
      end
      ST_MEM_LATCH: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ram1_en   = 1'b1;
    ram1_oe   = 1'b1;
    ram1_we   = 1'b1;
    rdn       = 1'b1;
    wrn       = 1'b1;
    bus_drive = 1'b0;
    if_valid  = 1'b0;
    mem_done  = 1'b0;
    case (state_q)
      ST_IF_SETUP: begin
        ram1_en = 1'b0;
        ram1_oe = 1'b0;
      end
      ST_IF_LATCH: begin
        ram1_en  = 1'b0;
        if_valid = 1'b1;
      end
      ST_MEM_SETUP: begin
        if (tgt_q == TGT_RAM1) begin
          ram1_en   = 1'b0;
          ram1_we   = ~we_q;
          ram1_oe   = we_q;
          bus_drive = we_q;
        end else if (tgt_q == TGT_UART_DATA) begin
          wrn       = ~we_q;
          rdn       = we_q;
          bus_drive = we_q;
        end
      end
      ST_MEM_LATCH: begin
        mem_done = 1'b1;
        if (tgt_q == TGT_RAM1) ram1_en = 1'b0;
        bus_drive = we_q & ((tgt_q == TGT_RAM1) | (tgt_q == TGT_UART_DATA));
      end
      default: ;
    endcase
  end

  assign bus_out   = (tgt_q == TGT_UART_DATA) ? {8'b0, wdata_q[7:0]} : wdata_q;
  assign ram1_data = bus_drive ? bus_out : 16'hzzzz;
  assign ram1_addr = {2'b00, addr_q};

  assign if_stall  = mem_hit & (state_q != ST_IF_SETUP) & (state_q != ST_IF_LATCH);
  assign if_instr  = if_stall ? NOP_INSTR : if_instr_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_ram1_bus_arbiter.sv
// Directed bench for ram1_bus_arbiter with a small RAM1 and UART pin model.
module tb_ram1_bus_arbiter;

  logic        clk = 1'b1;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_pc = 16'h0;
  logic        if_valid;
  logic [15:0] if_instr;
  logic        if_stall;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [15:0] mem_addr = 16'h0;
  logic [15:0] mem_wdata = 16'h0;
  logic [15:0] mem_rdata;
  logic        mem_done;
  wire  [15:0] ram1_data;
  logic [17:0] ram1_addr;
  logic        ram1_oe, ram1_we, ram1_en, rdn, wrn;
  logic        tbre = 1'b0, tsre = 1'b0, data_ready = 1'b0;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [15:0] ram [0:255];
  logic [15:0] uart_rx = 16'hA55A;
  logic [15:0] uart_tx = 16'h0000;
  logic        ram_drive, uart_drive;
  logic [15:0] ram_out;

  ram1_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_pc(if_pc), .if_valid(if_valid), .if_instr(if_instr), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram1_data(ram1_data), .ram1_addr(ram1_addr),
    .ram1_oe(ram1_oe), .ram1_we(ram1_we), .ram1_en(ram1_en),
    .rdn(rdn), .wrn(wrn), .tbre(tbre), .tsre(tsre), .data_ready(data_ready)
  );

  always #5 clk = ~clk;

  assign ram_drive  = !ram1_en && !ram1_oe;
  assign uart_drive = !rdn;
  assign ram_out    = ram[ram1_addr[7:0]];
  assign ram1_data  = ram_drive ? ram_out : 16'hzzzz;
  assign ram1_data  = uart_drive ? uart_rx : 16'hzzzz;

  always @(posedge ram1_we) if (rst && !ram1_en) ram[ram1_addr[7:0]] = ram1_data;
  always @(posedge wrn) if (rst) uart_tx = ram1_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_mem(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = wdata;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    chk_cnt++;
    if ({ram1_oe, ram1_we, ram1_en, rdn, wrn} !== 5'b11111)
      $display("FAIL reset_strobes got=%b exp=11111", {ram1_oe, ram1_we, ram1_en, rdn, wrn});
    else pass_cnt++;
    chk_cnt++;
    if ({if_valid, mem_done, if_stall} !== 3'b000)
      $display("FAIL reset_flags got=%b exp=000", {if_valid, mem_done, if_stall});
    else pass_cnt++;
    chk_cnt++;
    if (if_instr !== 16'h0800) $display("FAIL reset_if_instr got=%h exp=0800", if_instr);
    else pass_cnt++;
    chk_cnt++;
    if (mem_rdata !== 16'h0000 || ram1_addr !== 18'h0)
      $display("FAIL reset_rdata_addr got=%h/%h exp=0000/00000", mem_rdata, ram1_addr);
    else pass_cnt++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    if_req = 1'b1;
    if_pc  = 16'h0004;
    tick();
    chk_cnt++;
    if ({ram1_en, ram1_oe, ram1_we} !== 3'b001 || ram1_addr !== 18'h00004)
      $display("FAIL fetch_setup got en/oe/we=%b addr=%h exp=001 00004", {ram1_en, ram1_oe, ram1_we}, ram1_addr);
    else pass_cnt++;
    chk_cnt++;
    if (if_valid !== 1'b0) $display("FAIL fetch_early_valid got=%b exp=0", if_valid);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (if_valid !== 1'b1 || if_instr !== 16'h6801 || ram1_oe !== 1'b1)
      $display("FAIL fetch_latch got valid=%b instr=%h oe=%b exp=1 6801 1", if_valid, if_instr, ram1_oe);
    else pass_cnt++;
    if_req = 1'b0;
    tick();
    chk_cnt++;
    if (if_valid !== 1'b0) $display("FAIL fetch_pulse got=%b exp=0", if_valid);
    else pass_cnt++;
  endtask

  task automatic test_conflict();
    bit seen = 0;
    if_req = 1'b1;
    if_pc  = 16'h0005;
    issue_mem(1'b0, 16'h0010, 16'h0);
    #1;
    chk_cnt++;
    if (if_stall !== 1'b1 || if_instr !== 16'h0800)
      $display("FAIL conflict_stall_idle got stall=%b instr=%h exp=1 0800", if_stall, if_instr);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (ram1_addr !== 18'h00010 || ram1_oe !== 1'b0 || if_stall !== 1'b1)
      $display("FAIL conflict_mem_first got addr=%h oe=%b stall=%b exp=00010 0 1", ram1_addr, ram1_oe, if_stall);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (mem_done !== 1'b1 || mem_rdata !== 16'h1234 || if_valid !== 1'b0)
      $display("FAIL conflict_mem_done got done=%b rdata=%h valid=%b exp=1 1234 0", mem_done, mem_rdata, if_valid);
    else pass_cnt++;
    mem_req = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      tick();
      if (if_valid) seen = 1;
    end
    chk_cnt++;
    if (!seen || if_instr !== 16'h4A3C)
      $display("FAIL conflict_fetch_after got seen=%b instr=%h exp=1 4a3c", seen, if_instr);
    else pass_cnt++;
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_ram1_write();
    issue_mem(1'b1, 16'h0020, 16'hBEEF);
    tick();
    chk_cnt++;
    if ({ram1_en, ram1_we, ram1_oe} !== 3'b001 || ram1_data !== 16'hBEEF)
      $display("FAIL wr_setup got en/we/oe=%b bus=%h exp=001 beef", {ram1_en, ram1_we, ram1_oe}, ram1_data);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (ram1_we !== 1'b1 || mem_done !== 1'b1 || ram1_data !== 16'hBEEF)
      $display("FAIL wr_latch got we=%b done=%b bus=%h exp=1 1 beef", ram1_we, mem_done, ram1_data);
    else pass_cnt++;
    mem_req = 1'b0;
    tick();
    chk_cnt++;
    if (mem_done !== 1'b0 || ram[8'h20] !== 16'hBEEF)
      $display("FAIL wr_result got done=%b ram=%h exp=0 beef", mem_done, ram[8'h20]);
    else pass_cnt++;
    issue_mem(1'b0, 16'h0020, 16'h0);
    tick(); tick();
    chk_cnt++;
    if (mem_done !== 1'b1 || mem_rdata !== 16'hBEEF)
      $display("FAIL wr_readback got done=%b rdata=%h exp=1 beef", mem_done, mem_rdata);
    else pass_cnt++;
    mem_req = 1'b0;
    tick();
  endtask

  task automatic test_uart();
    issue_mem(1'b1, 16'hBF00, 16'h1241);
    tick();
    chk_cnt++;
    if ({wrn, rdn, ram1_en} !== 3'b011 || ram1_data !== 16'h0041)
      $display("FAIL uart_wr_setup got wrn/rdn/en=%b bus=%h exp=011 0041", {wrn, rdn, ram1_en}, ram1_data);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (wrn !== 1'b1 || mem_done !== 1'b1 || uart_tx !== 16'h0041)
      $display("FAIL uart_wr_latch got wrn=%b done=%b tx=%h exp=1 1 0041", wrn, mem_done, uart_tx);
    else pass_cnt++;
    mem_req = 1'b0;
    tick();
    issue_mem(1'b0, 16'hBF00, 16'h0);
    tick();
    chk_cnt++;
    if ({rdn, wrn, ram1_en} !== 3'b011)
      $display("FAIL uart_rd_setup got rdn/wrn/en=%b exp=011", {rdn, wrn, ram1_en});
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (rdn !== 1'b1 || mem_done !== 1'b1 || mem_rdata !== 16'h005A)
      $display("FAIL uart_rd_latch got rdn=%b done=%b rdata=%h exp=1 1 005a", rdn, mem_done, mem_rdata);
    else pass_cnt++;
    mem_req = 1'b0;
    tick();
  endtask

  task automatic test_cmd();
    logic [15:0] exp_status;
`ifdef UART_STATUS_EN
    exp_status = 16'h0003;
`else
    exp_status = 16'h0000;
`endif
    tbre = 1'b1; tsre = 1'b1; data_ready = 1'b1;
    issue_mem(1'b0, 16'hBF01, 16'h0);
    tick();
    chk_cnt++;
    if ({rdn, wrn, ram1_en, ram1_oe} !== 4'b1111)
      $display("FAIL cmd_rd_strobes got=%b exp=1111", {rdn, wrn, ram1_en, ram1_oe});
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (mem_done !== 1'b1 || mem_rdata !== exp_status)
      $display("FAIL cmd_rd_data got done=%b rdata=%h exp=1 %h", mem_done, mem_rdata, exp_status);
    else pass_cnt++;
    mem_req = 1'b0;
    tick();
    issue_mem(1'b1, 16'hBF01, 16'h00FF);
    tick();
    chk_cnt++;
    if ({rdn, wrn, ram1_en, ram1_we} !== 4'b1111)
      $display("FAIL cmd_wr_strobes got=%b exp=1111", {rdn, wrn, ram1_en, ram1_we});
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (mem_done !== 1'b1) $display("FAIL cmd_wr_done got=%b exp=1", mem_done);
    else pass_cnt++;
    mem_req = 1'b0;
    tbre = 1'b0; tsre = 1'b0; data_ready = 1'b0;
    tick();
  endtask

  task automatic test_ram2_bypass();
    bit any_done = 0;
    issue_mem(1'b0, 16'h9000, 16'h0);
    for (int n = 0; n < 3; n++) begin
      tick();
      if (mem_done || !ram1_en || if_stall) any_done = 1;
    end
    chk_cnt++;
    if (any_done) $display("FAIL ram2_no_grant got activity=1 exp=0");
    else pass_cnt++;
    if_req = 1'b1;
    if_pc  = 16'h0004;
    tick(); tick();
    chk_cnt++;
    if (if_valid !== 1'b1 || if_instr !== 16'h6801 || if_stall !== 1'b0)
      $display("FAIL ram2_fetch got valid=%b instr=%h stall=%b exp=1 6801 0", if_valid, if_instr, if_stall);
    else pass_cnt++;
    if_req  = 1'b0;
    mem_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    bit seen_done = 0;
    issue_mem(1'b1, 16'h0030, 16'h5555);
    tick();
    chk_cnt++;
    if (ram1_we !== 1'b0) $display("FAIL rstmid_in_setup got we=%b exp=0", ram1_we);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    chk_cnt++;
    if ({ram1_oe, ram1_we, ram1_en, rdn, wrn} !== 5'b11111)
      $display("FAIL rstmid_strobes got=%b exp=11111", {ram1_oe, ram1_we, ram1_en, rdn, wrn});
    else pass_cnt++;
    for (int n = 0; n < 2; n++) begin
      tick();
      if (mem_done) seen_done = 1;
    end
    mem_req = 1'b0;
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (mem_done) seen_done = 1;
    end
    chk_cnt++;
    if (seen_done || ram1_addr !== 18'h0 || ram[8'h30] !== 16'h0000)
      $display("FAIL rstmid_abort got done=%b addr=%h ram=%h exp=0 00000 0000", seen_done, ram1_addr, ram[8'h30]);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    ram[4]     = 16'h6801;
    ram[5]     = 16'h4A3C;
    ram[8'h10] = 16'h1234;
    test_reset();
    test_fetch();
    test_conflict();
    test_ram1_write();
    test_uart();
    test_cmd();
    test_ram2_bypass();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
